sync_rst_dff_pipe: RTL and testbench

Parameterised data register pipeline with synchronous, active-low reset. Used as the standard registered-output stage wherever a signal must be retimed by a fixed number of cycles and forced to a known value on reset. The default build (WIDTH=1, STAGES=1) is a single D flip-flop with synchronous reset. Reset affects state only on a rising clock edge, never between edges.

---
 rtl/sync_rst_dff_pipe_pkg.sv | 19 +
 rtl/sync_rst_dff.sv | 32 +++
 rtl/sync_rst_dff_pipe.sv | 67 ++++++
 tb/tb_sync_rst_dff_pipe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sync_rst_dff_pipe_pkg.sv
// rtl/sync_rst_dff_pipe_pkg.sv - shared defaults for the synchronous-reset register pipeline
//
// Contents:
//   DEF_WIDTH, DEF_STAGES : default data width and pipeline depth
//   MAX_WIDTH             : widest reset value def_rst_val can describe
//   def_rst_val(width)    : all-zero reset value; callers size-cast it to their width
package sync_rst_dff_pipe_pkg;

  localparam int DEF_WIDTH  = 1;
  localparam int DEF_STAGES = 1;
  localparam int MAX_WIDTH  = 1024;

  // Zero in the low `width` bits. Every bit above `width` is also zero, so a
  // caller's size cast down to `width` bits loses nothing.
  function automatic logic [MAX_WIDTH-1:0] def_rst_val(input int width);
    return ~({MAX_WIDTH{1'b1}} << width) & {MAX_WIDTH{1'b0}};
  endfunction

endpackage

// File: rtl/sync_rst_dff.sv
// rtl/sync_rst_dff.sv - one WIDTH-bit flop with synchronous active-low reset
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low; loads RST_VAL at a posedge with rst==0
//   i_d  : data input, sampled on rising clk
//   o_q  : registered output
module sync_rst_dff
  import sync_rst_dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(def_rst_val(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_rst_dff_pipe.sv
// rtl/sync_rst_dff_pipe.sv - STAGES-deep data register pipeline with synchronous active-low reset
//
// Optional build macro: SYNC_RST_DFF_PIPE_RST_REG_EN
//   defined   : rst is registered once (rst_q) and the stages reset from rst_q,
//               so reset assertion and release land one posedge later
//   undefined : the stages reset directly from rst
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low (0 = reset)
//   in   : WIDTH-bit data input, sampled on rising clk
//   out  : WIDTH-bit output, driven straight from the last stage flop
module sync_rst_dff_pipe
  import sync_rst_dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               STAGES  = DEF_STAGES,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(def_rst_val(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
    $fatal(1, "sync_rst_dff_pipe: WIDTH and STAGES must both be >= 1");
  end

  logic w_rst;

`ifdef SYNC_RST_DFF_PIPE_RST_REG_EN
  // Data input tied high: the flop reads 0 at a posedge with rst==0 and 1
  // at a posedge with rst==1, i.e. a one-edge delayed copy of rst.
  sync_rst_dff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_rst_reg (
    .clk (clk),
    .rst (rst),
    .i_d (1'b1),
    .o_q (w_rst)
  );
`else
  assign w_rst = rst;
`endif

  // w_stage[0] is the pipeline input; w_stage[g+1] is the output of stage g.
  logic [WIDTH-1:0] w_stage [STAGES+1];

  assign w_stage[0] = in;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    sync_rst_dff #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_dff (
      .clk (clk),
      .rst (w_rst),
      .i_d (w_stage[g]),
      .o_q (w_stage[g+1])
    );
  end

  assign out = w_stage[STAGES];

endmodule

// File: tb/tb_sync_rst_dff_pipe.sv
// tb/tb_sync_rst_dff_pipe.sv - self-checking bench for sync_rst_dff_pipe (1x1 default and 8x3 pipe)
module tb_sync_rst_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d1_rst, d1_in, d1_out;
  logic       d3_rst;
  logic [7:0] d3_in, d3_out;

  sync_rst_dff_pipe u_dut1 (
    .clk (clk),
    .rst (d1_rst),
    .in  (d1_in),
    .out (d1_out)
  );

  sync_rst_dff_pipe #(
    .WIDTH   (8),
    .STAGES  (3),
    .RST_VAL (8'hA5)
  ) u_dut3 (
    .clk (clk),
    .rst (d3_rst),
    .in  (d3_in),
    .out (d3_out)
  );

  // exp: output after the following posedge in the default build;
  // exp_rq: the same with the registered-reset build.
  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic [7:0] exp;
    logic [7:0] exp_rq;
  } vec_t;

  vec_t       v1 [12];
  vec_t       v3 [11];
  logic [7:0] q1 [$];
  logic [7:0] q3 [$];
  int         total = 0;
  int         bad   = 0;
  int         n1    = 0;
  int         n3    = 0;

  function automatic void chk(input string name, input int idx,
                              input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endfunction

  function automatic logic [7:0] sel(input logic [7:0] plain, input logic [7:0] reg_rst);
`ifdef SYNC_RST_DFF_PIPE_RST_REG_EN
    return reg_rst;
`else
    return plain;
`endif
  endfunction

  // Scoreboards: expectations are queued at the negedge that drives the
  // stimulus and consumed just after the next posedge.
  always @(posedge clk) begin
    #1;
    if (q1.size() > 0) begin
      chk("dut1_out", n1, {7'b0, d1_out}, q1.pop_front());
      n1++;
    end
    if (q3.size() > 0) begin
      chk("dut3_out", n3, d3_out, q3.pop_front());
      n3++;
    end
  end

  task automatic reset_release_seq(input int pass);
    @(negedge clk);
    d1_rst = 1'b0;
    d1_in  = 1'b1;
    #1 chk("rst_fall_no_effect", pass, {7'b0, d1_out}, 8'h01);
    q1.push_back(sel(8'h00, 8'h01));
    @(negedge clk);
    q1.push_back(8'h00);
    @(negedge clk);
    q1.push_back(8'h00);
    @(negedge clk);
    d1_rst = 1'b1;
    q1.push_back(sel(8'h01, 8'h00));
    @(negedge clk);
    q1.push_back(8'h01);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    v1[0]  = '{1'b0, 8'h00, 8'h00, 8'h00};
    v1[1]  = '{1'b0, 8'h01, 8'h00, 8'h00};
    v1[2]  = '{1'b1, 8'h01, 8'h01, 8'h00};
    v1[3]  = '{1'b1, 8'h00, 8'h00, 8'h00};
    v1[4]  = '{1'b1, 8'h01, 8'h01, 8'h01};
    v1[5]  = '{1'b0, 8'h01, 8'h00, 8'h01};
    v1[6]  = '{1'b0, 8'h01, 8'h00, 8'h00};
    v1[7]  = '{1'b0, 8'h01, 8'h00, 8'h00};
    v1[8]  = '{1'b1, 8'h01, 8'h01, 8'h00};
    v1[9]  = '{1'b1, 8'h00, 8'h00, 8'h00};
    v1[10] = '{1'b1, 8'h01, 8'h01, 8'h01};
    v1[11] = '{1'b1, 8'h01, 8'h01, 8'h01};

    v3[0]  = '{1'b1, 8'h01, 8'hA5, 8'hA5};
    v3[1]  = '{1'b1, 8'h02, 8'hA5, 8'hA5};
    v3[2]  = '{1'b1, 8'h03, 8'h01, 8'hA5};
    v3[3]  = '{1'b1, 8'h04, 8'h02, 8'h02};
    v3[4]  = '{1'b1, 8'h05, 8'h03, 8'h03};
    v3[5]  = '{1'b0, 8'h06, 8'hA5, 8'h04};
    v3[6]  = '{1'b1, 8'h07, 8'hA5, 8'hA5};
    v3[7]  = '{1'b1, 8'h08, 8'hA5, 8'hA5};
    v3[8]  = '{1'b1, 8'h09, 8'h07, 8'hA5};
    v3[9]  = '{1'b1, 8'h0A, 8'h08, 8'h08};
    v3[10] = '{1'b1, 8'h0B, 8'h09, 8'h09};

    d1_rst = 1'b0;
    d1_in  = 1'b0;
    d3_rst = 1'b0;
    d3_in  = 8'h00;

    // Two reset edges bring both builds (with or without rst_q) to a known state.
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      d1_rst = v1[i].rst;
      d1_in  = v1[i].din[0];
      q1.push_back(sel(v1[i].exp, v1[i].exp_rq));
    end

    // Low pulse on rst strictly between edges: no reset is taken.
    @(negedge clk);
    d1_in = 1'b1;
    #2 d1_rst = 1'b0;
    #2 d1_rst = 1'b1;
    chk("glitch_mid", 0, {7'b0, d1_out}, 8'h01);
    q1.push_back(8'h01);
    @(negedge clk);
    q1.push_back(8'h01);

    reset_release_seq(0);
    #50;
    reset_release_seq(1);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      d3_rst = v3[i].rst;
      d3_in  = v3[i].din;
      q3.push_back(sel(v3[i].exp, v3[i].exp_rq));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 0, 8'(q1.size() + q3.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
